// File: rtl/fwft_fifo_arb_pkg.sv
// Shared types and helpers for the FWFT FIFO write arbiter.
package fwft_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // Index width that never collapses to zero, so two requesters still get a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fwft_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N_REQ.
module fwft_rr_pick
  import fwft_fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W:0]     pos;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;

  // Rotate the doubled request vector by ptr, priority-encode, then map back to an absolute index.
  always_comb begin
    dbl = {req, req};
    rot = '0;
    pos = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos    = {1'b0, ptr} + (IDX_W+1)'(i);
      rot[i] = dbl[pos];
    end
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    gnt_idx = sum[IDX_W-1:0];
    gnt_vld = |req;
  end

endmodule

// File: rtl/fwft_fifo_wr_arb.sv
// Round-robin, burst-locked write arbiter in front of a single FWFT FIFO write port.
// A grant is held until end of packet, the burst limit, or an idle timeout; data is
// forwarded combinationally so the granted requester sees the FIFO directly.
module fwft_fifo_wr_arb
  import fwft_fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32,
  localparam int IDX_W    = clog2_min1(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_rdy,
  output logic                        fifo_wren,
  output logic [WIDTH-1:0]            fifo_wdata,
  output logic [IDX_W-1:0]            fifo_wsrc,
  input  logic                        fifo_full,
  output logic                        busy,
  output logic [IDX_W-1:0]            cur_src
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int ICNT_W = clog2_min1(TIMEOUT + 1);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic [ICNT_W-1:0] IDLE_LAST  = ICNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]  SRC_LAST   = IDX_W'(N_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cur_src_q, cur_src_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ICNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              cur_vld;
  logic              cur_last;
  logic              xfer;
  logic              release_lock;

  fwft_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Arbitration in IDLE, transfer/burst/idle accounting and release decision in LOCK.
  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    req_rdy      = '0;
    fifo_wdata   = '0;
    xfer         = 1'b0;
    release_lock = 1'b0;
    cur_vld      = req_vld[cur_src_q];
    cur_last     = req_last[cur_src_q];

    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d     = ARB_LOCK;
          cur_src_d   = pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      ARB_LOCK: begin
        req_rdy[cur_src_q] = !fifo_full;
        fifo_wdata         = req_data[cur_src_q];
        xfer               = cur_vld && !fifo_full;
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          idle_cnt_d  = '0;
          if (cur_last || (burst_cnt_q == BURST_LAST)) release_lock = 1'b1;
        end else if (!cur_vld) begin
          // A stalled valid word leaves the idle counter untouched.
          if (idle_cnt_q != {ICNT_W{1'b1}}) idle_cnt_d = idle_cnt_q + ICNT_W'(1);
          if ((TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST)) release_lock = 1'b1;
        end
        if (release_lock) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (cur_src_q == SRC_LAST) ? '0 : cur_src_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Control and grant state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      cur_src_q   <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign fifo_wren = xfer;
  assign fifo_wsrc = cur_src_q;
  assign busy      = (state_q == ARB_LOCK);
  assign cur_src   = cur_src_q;

endmodule

// File: tb/tb_fwft_fifo_wr_arb.sv
// Bench for fwft_fifo_wr_arb: cycle vectors for a single packet, then requester models
// feeding a scoreboard for fairness, burst limit, backpressure, timeout and reset cases.
module tb_fwft_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_vld;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_rdy;
  logic                fifo_wren;
  logic [W-1:0]        fifo_wdata;
  logic [IW-1:0]       fifo_wsrc;
  logic                fifo_full;
  logic                busy;
  logic [IW-1:0]       cur_src;

  fwft_fifo_wr_arb #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (16),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_wsrc  (fifo_wsrc),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .cur_src    (cur_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
  } word_t;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       full;
    logic       busy;
    logic       rdy;
    logic       wren;
    logic [7:0] wdata;
  } vec_t;

  word_t  pend[$];
  word_t  sb[$];
  int     gnt_src[$];
  int     gnt_cyc[$];
  int     gnt_len[$];
  int     lastwr[N];
  logic [N-1:0] en_mask;
  logic   busy_prev;
  int     n_chk, n_pass, cyc, n_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int find_pend(input int s);
    for (int i = 0; i < pend.size(); i++) if (pend[i].src == s) return i;
    return -1;
  endfunction

  function automatic int find_sb(input int s);
    for (int i = 0; i < sb.size(); i++) if (sb[i].src == s) return i;
    return -1;
  endfunction

  task automatic load(input int s, input logic [7:0] d, input logic l);
    word_t w;
    w.src = s; w.data = d; w.last = l;
    pend.push_back(w);
    sb.push_back(w);
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      int k;
      k = find_pend(s);
      if (k >= 0 && en_mask[s]) begin
        req_vld[s] = 1'b1; req_data[s] = pend[k].data; req_last[s] = pend[k].last;
      end else begin
        req_vld[s] = 1'b0; req_data[s] = '0; req_last[s] = 1'b0;
      end
    end
  endtask

  // One clock: observe at the falling edge, then retire/represent words just after the rising edge.
  task automatic tick();
    int   s, k;
    logic xf;
    cyc++;
    @(negedge clk);
    chk("rdy_onehot", ($countones(req_rdy) <= 1), 1);
    if (busy && !busy_prev) begin
      gnt_src.push_back(int'(cur_src));
      gnt_cyc.push_back(cyc);
      gnt_len.push_back(0);
    end
    busy_prev = busy;
    xf = fifo_wren;
    s  = int'(fifo_wsrc);
    if (xf) begin
      n_wr++;
      lastwr[s] = cyc;
      if (gnt_len.size() > 0) gnt_len[gnt_len.size()-1] = gnt_len[gnt_len.size()-1] + 1;
      k = find_sb(s);
      chk("sb_expected_word", (k >= 0), 1);
      if (k >= 0) begin
        chk($sformatf("sb_data_src%0d", s), fifo_wdata, sb[k].data);
        sb.delete(k);
      end
    end
    @(posedge clk);
    #1;
    if (xf) begin
      k = find_pend(s);
      if (k >= 0) pend.delete(k);
    end
    drive();
  endtask

  task automatic run_done(input string nm, input int budget);
    int   n;
    logic done;
    n = 0;
    done = (pend.size() == 0 && sb.size() == 0 && !busy);
    while (!done && n < budget) begin
      tick();
      n++;
      done = (pend.size() == 0 && sb.size() == 0 && !busy);
    end
    chk({nm, "_completed"}, done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend.delete();
    sb.delete();
    en_mask   = '1;
    fifo_full = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    busy_prev = 1'b0;
    gnt_src.delete(); gnt_cyc.delete(); gnt_len.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tv[9];
    int   exp_src[4];
    int   exp_len[4];
    int   cnt[N];
    int   bad, n, w0;

    n_chk = 0; n_pass = 0; cyc = 0; n_wr = 0;
    busy_prev = 1'b0;
    for (int s = 0; s < N; s++) lastwr[s] = 0;

    // Reset state, with all requesters asserting and nonzero data present.
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    en_mask   = '1;
    req_vld   = '1;
    req_last  = '0;
    for (int s = 0; s < N; s++) req_data[s] = 8'hAA;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_wren", fifo_wren, 0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_wsrc", fifo_wsrc, 0);
    chk("rst_cur_src", cur_src, 0);
    @(negedge clk);
    chk("rst_hold_busy", busy, 0);

    // Single requester, cycle by cycle, including a one-cycle full stall.
    tv[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
    tv[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tv[3] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12};
    tv[4] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12};
    tv[5] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13};
    tv[6] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h14};
    tv[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_vld     = {3'b000, tv[i].vld};
      req_last    = {3'b000, tv[i].last};
      req_data[0] = tv[i].data;
      fifo_full   = tv[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("vec%0d_rdy", i), req_rdy, {3'b000, tv[i].rdy});
      chk($sformatf("vec%0d_wren", i), fifo_wren, tv[i].wren);
      chk($sformatf("vec%0d_wdata", i), fifo_wdata, tv[i].wdata);
      chk($sformatf("vec%0d_wsrc", i), fifo_wsrc, 0);
      @(posedge clk);
      #1;
    end

    // Round-robin fairness: four sources, ten 2-word packets each.
    do_reset();
    for (int p = 0; p < 10; p++)
      for (int s = 0; s < N; s++)
        for (int w = 0; w < 2; w++) load(s, 8'(s * 64 + p * 2 + w), (w == 1));
    drive();
    run_done("rr", 600);
    chk("rr_ngrants", gnt_src.size(), 40);
    for (int s = 0; s < N; s++) cnt[s] = 0;
    for (int i = 0; i < gnt_src.size() && i < 40; i++) begin
      chk($sformatf("rr_order%0d", i), gnt_src[i], i % 4);
      if (gnt_src[i] >= 0 && gnt_src[i] < N) cnt[gnt_src[i]]++;
    end
    for (int s = 0; s < N; s++) chk($sformatf("rr_count_src%0d", s), cnt[s], 10);
    bad = 0;
    for (int i = 1; i < gnt_cyc.size(); i++) if (gnt_cyc[i] - gnt_cyc[i-1] != 3) bad++;
    chk("rr_gap_violations", bad, 0);
    bad = 0;
    for (int i = 0; i < gnt_len.size(); i++) if (gnt_len[i] != 2) bad++;
    chk("rr_len_violations", bad, 0);

    // Burst limit: source 2 streams 40 words without last while source 3 waits.
    do_reset();
    for (int i = 0; i < 40; i++) load(2, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) load(3, 8'(8'hA0 + i), (i == 2));
    drive();
    run_done("burst", 300);
    exp_src = '{2, 3, 2, 2};
    exp_len = '{16, 3, 16, 8};
    chk("burst_ngrants", gnt_src.size(), 4);
    for (int i = 0; i < gnt_src.size() && i < 4; i++) begin
      chk($sformatf("burst_src%0d", i), gnt_src[i], exp_src[i]);
      chk($sformatf("burst_len%0d", i), gnt_len[i], exp_len[i]);
    end
    if (gnt_cyc.size() >= 2) chk("burst_dead_cycle", gnt_cyc[1] - gnt_cyc[0], 17);
    else chk("burst_dead_cycle_grants", gnt_cyc.size(), 2);

    // Backpressure: 10 full cycles in the middle of a packet from source 1.
    do_reset();
    for (int i = 0; i < 6; i++) load(1, 8'(8'h30 + i), (i == 5));
    drive();
    w0 = n_wr; n = 0;
    while (n_wr - w0 < 2 && n < 20) begin tick(); n++; end
    chk("bp_prefix_writes", n_wr - w0, 2);
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), req_rdy, 0);
      chk($sformatf("bp_wren%0d", i), fifo_wren, 0);
      chk($sformatf("bp_busy%0d", i), busy, 1);
      tick();
    end
    fifo_full = 1'b0;
    run_done("bp", 100);
    chk("bp_ngrants", gnt_src.size(), 1);
    if (gnt_len.size() > 0) chk("bp_len", gnt_len[0], 6);

    // Timeout: source 0 stops mid-packet, source 1 waits.
    do_reset();
    for (int i = 0; i < 3; i++) load(0, 8'(8'h40 + i), 1'b0);
    load(1, 8'h50, 1'b0);
    load(1, 8'h51, 1'b1);
    drive();
    run_done("to", 100);
    chk("to_ngrants", gnt_src.size(), 2);
    if (gnt_src.size() >= 2) begin
      chk("to_src0", gnt_src[0], 0);
      chk("to_src1", gnt_src[1], 1);
      chk("to_len0", gnt_len[0], 3);
      chk("to_len1", gnt_len[1], 2);
      chk("to_release_delay", gnt_cyc[1] - lastwr[0], 10);
    end

    // Reset during the 3rd transfer of source 1, with rr_ptr moved away from 0 beforehand.
    do_reset();
    load(2, 8'h60, 1'b1);
    drive();
    run_done("rm_pre", 20);
    for (int i = 0; i < 6; i++) load(1, 8'(8'h70 + i), (i == 5));
    drive();
    w0 = n_wr; n = 0;
    while (n_wr - w0 < 2 && n < 20) begin tick(); n++; end
    @(negedge clk);
    chk("rm_third_wren", fifo_wren, 1);
    chk("rm_third_src", fifo_wsrc, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_wren_low", fifo_wren, 0);
    chk("rm_rdy_low", req_rdy, 0);
    chk("rm_busy_low", busy, 0);
    chk("rm_cur_src", cur_src, 0);
    pend.delete();
    sb.delete();
    drive();
    @(posedge clk);
    #1;
    load(2, 8'h80, 1'b1);
    load(3, 8'h90, 1'b1);
    drive();
    @(posedge clk);
    #1;
    chk("rm_held_idle", busy, 0);
    rst_n = 1'b1;
    busy_prev = 1'b0;
    gnt_src.delete(); gnt_cyc.delete(); gnt_len.delete();
    run_done("rm_post", 50);
    chk("rm_ngrants", gnt_src.size(), 2);
    if (gnt_src.size() >= 2) begin
      chk("rm_first_grant", gnt_src[0], 2);
      chk("rm_second_grant", gnt_src[1], 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
